hci_mem_bank_ctrl: RTL
======================

HCI_MEM_BANK_CTRL -- requirements
Module: hci_mem_bank_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32: memory word address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter BW, default 8: byte width; DW/BW byte enables.
REQ-004 SHALL have parameter IW, default 16: request ID width.
REQ-005 SHALL have parameter UW, default 1: user width.
REQ-006 SHALL have parameter RD_LAT, default 1, legal range 1..3: SRAM read latency in cycles.
REQ-007 SHALL have parameter TS_BIT, default 21, must be < AW: test-and-set address bit.
REQ-008 SHALL have one clock; reset is asynchronous and active-high. Ports: clk_i  in  1  clock; rst_i  in  1  async active-high reset.
REQ-009 SHALL have port clear_i  in  1  synchronous flush.
REQ-010 SHALL have ports req_i in 1; gnt_o out 1; add_i in AW; wen_i in 1 (1=read, 0=write); data_i in DW; be_i in DW/BW; id_i in IW; user_i in UW. This is the interconnect-facing bank request.
REQ-011 SHALL have ports r_valid_o out 1; r_data_o out DW; r_id_o out IW; r_user_o out UW. This is the response.
REQ-012 SHALL have ports sram_req_o out 1; sram_we_o out 1; sram_addr_o out AW; sram_wdata_o out DW; sram_be_o out DW/BW; sram_rdata_i in DW. This is the SRAM macro.

Function
REQ-013 SHALL contain FSM states IDLE and TS_WAIT.
REQ-014 IDLE: gnt_o SHALL be 1 combinationally, independent of req_i.
REQ-015 A transfer SHALL occur when req_i & gnt_o. The same cycle SHALL drive sram_req_o=1, sram_we_o=~wen_i, sram_addr_o=add_i with bit TS_BIT cleared, sram_wdata_o=data_i, sram_be_o=be_i.
REQ-016 Each transfer SHALL push {valid, id, user, is_read, is_ts} into an RD_LAT-deep shift pipeline.
REQ-017 r_valid_o, r_id_o, r_user_o SHALL come from the last pipeline stage. Response arrives exactly RD_LAT cycles after grant, for reads and writes alike.
REQ-018 r_data_o SHALL equal sram_rdata_i for reads and 0 for writes. When r_valid_o=0, r_data_o SHALL be 0.
REQ-019 A read with add_i[TS_BIT]=1 SHALL be a test-and-set. It is granted as a normal read, and the FSM moves IDLE->TS_WAIT.
REQ-020 TS_WAIT: gnt_o SHALL be 0. A held ts address SHALL be kept for the SRAM write.
REQ-021 When the ts entry reaches the last pipeline stage, the block SHALL return the old data (sram_rdata_i) on r_data_o. In the same cycle it SHALL issue an SRAM write: all-ones data, all-ones be, held address. The FSM then returns TS_WAIT->IDLE.
REQ-022 gnt_o SHALL resume the cycle after the ts write. Total stall is RD_LAT cycles.
REQ-023 Earlier pipeline entries SHALL drain normally during TS_WAIT, without reordering.
REQ-024 Back-to-back transfers SHALL sustain one per cycle in IDLE. No bubbles SHALL be inserted for read/write mixes.
REQ-025 When the SRAM is not issuing, the SRAM outputs other than sram_req_o are don't-care. sram_req_o SHALL be 0 when no transfer or ts write occurs.
REQ-026 clear_i SHALL synchronously zero all pipeline valids and force IDLE. Any pending ts write is dropped.
REQ-027 When clear_i is asserted, no response SHALL be emitted from the next cycle on. A request presented with clear_i SHALL NOT be granted (gnt_o=0).
REQ-028 Write responses SHALL carry r_id_o/r_user_o of the originating request.

Reset
REQ-029 rst_i SHALL asynchronously set: FSM=IDLE, all pipeline stages invalid, ts address=0.
REQ-030 During and after reset, outputs SHALL be: r_valid_o=0, r_data_o=0, r_id_o=0, r_user_o=0, sram_req_o=0.
REQ-031 Reset asserted mid-ts SHALL abort the ts write. After release, gnt_o=1.

Verification
REQ-032 RD_LAT=2, write 0xDEADBEEF to addr 0x10 with be=0xF and id=3, then read 0x10 with id=5. Expect: write response (r_valid_o=1, id=3, data 0) at t+2; read response id=5 with data 0xDEADBEEF at t+3.
REQ-033 RD_LAT=1, ten consecutive reads. Expect gnt_o=1 every cycle and ten responses in order, each 1 cycle after its grant.
REQ-034 RD_LAT=3, mem[0x20]=0x5, ts read with add=0x20|(1<<21). Expect: r_data_o=0x5 at t+3; gnt_o=0 for t+1..t+3; SRAM write of 0xFFFFFFFF to 0x20 at t+3; gnt_o=1 at t+4. A following plain read of 0x20 returns 0xFFFFFFFF.
REQ-035 RD_LAT=2, two reads then a ts, all back-to-back. Expect the three responses in order and no dropped response.
REQ-036 clear_i pulse with two reads in flight. Expect no r_valid_o afterward and FSM in IDLE.
REQ-037 rst_i asserted one cycle after a ts grant. Expect: no SRAM write, all outputs zero, gnt_o=1 after release.

Source files
------------

// File: rtl/hci_mem_bank_ctrl.sv
// rtl/hci_mem_bank_ctrl.sv - HCI memory bank controller: fixed-latency SRAM access with test-and-set
module hci_mem_bank_ctrl #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int BW     = 8,
    parameter int IW     = 16,
    parameter int UW     = 1,
    parameter int RD_LAT = 1,
    parameter int TS_BIT = 21
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [AW-1:0]      add_i,
    input  logic               wen_i,
    input  logic [DW-1:0]      data_i,
    input  logic [DW/BW-1:0]   be_i,
    input  logic [IW-1:0]      id_i,
    input  logic [UW-1:0]      user_i,
    output logic               r_valid_o,
    output logic [DW-1:0]      r_data_o,
    output logic [IW-1:0]      r_id_o,
    output logic [UW-1:0]      r_user_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [AW-1:0]      sram_addr_o,
    output logic [DW-1:0]      sram_wdata_o,
    output logic [DW/BW-1:0]   sram_be_o,
    input  logic [DW-1:0]      sram_rdata_i
);

    localparam int EW = IW + UW + 3;
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_TS_WAIT = 1'b1;
    localparam logic [AW-1:0] TS_MASK = AW'(1) << TS_BIT;

    logic            state_q, state_d;
    logic [AW-1:0]   ts_addr_q, ts_addr_d;
    logic [EW-1:0]   pipe_q [RD_LAT];
    logic [EW-1:0]   pipe_d [RD_LAT];
    logic [EW-1:0]   last_e;
    logic [AW-1:0]   addr_clr;
    logic            xfer, is_ts_req, ts_fire;
    logic            last_vld, last_rd, last_ts;

    // Grant is also withheld during reset so the SRAM sees no request while rst_i is high.
    assign gnt_o     = (state_q == ST_IDLE) && !clear_i && !rst_i;
    assign xfer      = req_i && gnt_o;
    assign is_ts_req = wen_i && add_i[TS_BIT];
    assign addr_clr  = add_i & ~TS_MASK;

    // Entry layout: {valid, id, user, is_read, is_ts}
    assign last_e    = pipe_q[RD_LAT-1];
    assign last_vld  = last_e[EW-1];
    assign last_rd   = last_e[1];
    assign last_ts   = last_e[0];
    assign ts_fire   = (state_q == ST_TS_WAIT) && last_vld && last_ts && !clear_i;

    assign r_valid_o = last_vld;
    assign r_id_o    = last_e[EW-2 -: IW];
    assign r_user_o  = last_e[UW+1 -: UW];
    assign r_data_o  = (last_vld && last_rd) ? sram_rdata_i : '0;

    assign sram_req_o   = xfer || ts_fire;
    assign sram_we_o    = ts_fire ? 1'b1 : !wen_i;
    assign sram_addr_o  = ts_fire ? ts_addr_q : addr_clr;
    assign sram_wdata_o = ts_fire ? '1 : data_i;
    assign sram_be_o    = ts_fire ? '1 : be_i;

    always_comb begin
        pipe_d[0] = {xfer, id_i, user_i, wen_i, is_ts_req};
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (clear_i) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_d[i] = '0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ts_addr_d = ts_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer && is_ts_req) begin
                    state_d   = ST_TS_WAIT;
                    ts_addr_d = addr_clr;
                end
            end
            ST_TS_WAIT: begin
                if (ts_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ts_addr_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ts_addr_q <= ts_addr_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

endmodule
